// File: rtl/scalefac_unpack.sv
// MPEG-1 Layer III scalefactor unpacking for one channel/granule: walks the
// long/short scalefactor band list, pulls slen-wide fields and writes them out.
//
// state | meaning
// IDLE  | waiting for stage_ready, sideinfo latched on start
// SEL   | pick next item and its width, skip scfsi-reused bands
// REQ   | bits_req held until bits_valid consumes the field
// ZERO  | zero-width item, value 0
// WR    | one write strobe to long or short memory, then advance
// DONE  | one-cycle stage_done
module scalefac_unpack (
  input  logic       clk,
  input  logic       rst,
  input  logic       stage_ready,
  output logic       stage_done,
  input  logic       granule,
  input  logic [3:0] sideinfo_scalefac_compress,
  input  logic [1:0] sideinfo_block_type,
  input  logic       sideinfo_window_switching_flag,
  input  logic       sideinfo_mixed_block_flag,
  input  logic [3:0] sideinfo_scfsi,
  output logic       bits_req,
  output logic [2:0] bits_count,
  input  logic [3:0] bits_data,
  input  logic       bits_valid,
  output logic       scalfac_long_write_enable,
  output logic [5:0] scalfac_long_write_addr,
  output logic [3:0] scalfac_long_write_data,
  output logic       scalfac_short_write_enable,
  output logic [1:0] scalfac_short_write_addr_window,
  output logic [3:0] scalfac_short_write_addr_index,
  output logic [3:0] scalfac_short_write_data
);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ, S_ZERO, S_WR, S_DONE} state_t;

  // Nibble n holds the slen value for scalefac_compress = n.
  localparam logic [63:0] SLEN1_TAB = 64'h4433_3222_1113_0000;
  localparam logic [63:0] SLEN2_TAB = 64'h3232_1321_3210_3210;

  state_t     state_q;
  logic [2:0] slen1_q, slen2_q, width_q;
  logic [3:0] reuse_q;
  logic       mixed_q, long_q;
  logic [4:0] sfb_q;
  logic [1:0] win_q;

  logic       done_q, req_q, lwe_q, swe_q;
  logic [2:0] cnt_q;
  logic [5:0] laddr_q;
  logic [3:0] ldata_q, sdata_q, sidx_q;
  logic [1:0] swin_q;

  logic       short_mode;
  logic [3:0] slen1_raw, slen2_raw, wr_val, mask;
  logic       sel_end, sel_skip;
  logic [2:0] sel_width;

  assign short_mode = sideinfo_window_switching_flag && (sideinfo_block_type == 2'd2);

  always_comb begin
    slen1_raw = SLEN1_TAB[{sideinfo_scalefac_compress, 2'b00} +: 4];
    slen2_raw = SLEN2_TAB[{sideinfo_scalefac_compress, 2'b00} +: 4];
  end

  always_comb begin
    sel_end   = 1'b0;
    sel_skip  = 1'b0;
    sel_width = 3'd0;
    if (long_q) begin
      if (sfb_q > 5'd21) begin
        sel_end = 1'b1;
      end else begin
        if (sfb_q < 5'd6)       sel_skip = reuse_q[0];
        else if (sfb_q < 5'd11) sel_skip = reuse_q[1];
        else if (sfb_q < 5'd16) sel_skip = reuse_q[2];
        else if (sfb_q < 5'd21) sel_skip = reuse_q[3];
        if (sfb_q < 5'd11)      sel_width = slen1_q;
        else if (sfb_q < 5'd21) sel_width = slen2_q;
      end
    end else begin
      if (sfb_q > 5'd12)      sel_end = 1'b1;
      else if (sfb_q < 5'd6)  sel_width = slen1_q;
      else if (sfb_q < 5'd12) sel_width = slen2_q;
    end
  end

  always_comb begin
    case (width_q)
      3'd1:    mask = 4'h1;
      3'd2:    mask = 4'h3;
      3'd3:    mask = 4'h7;
      3'd4:    mask = 4'hF;
      default: mask = 4'h0;
    endcase
    wr_val = (state_q == S_REQ) ? (bits_data & mask) : 4'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      slen1_q <= 3'd0;
      slen2_q <= 3'd0;
      width_q <= 3'd0;
      reuse_q <= 4'd0;
      mixed_q <= 1'b0;
      long_q  <= 1'b0;
      sfb_q   <= 5'd0;
      win_q   <= 2'd0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= 3'd0;
      lwe_q   <= 1'b0;
      laddr_q <= 6'd0;
      ldata_q <= 4'd0;
      swe_q   <= 1'b0;
      swin_q  <= 2'd0;
      sidx_q  <= 4'd0;
      sdata_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: if (stage_ready) begin
          slen1_q <= slen1_raw[2:0];
          slen2_q <= slen2_raw[2:0];
          reuse_q <= (granule && !short_mode) ? sideinfo_scfsi : 4'd0;
          mixed_q <= short_mode && sideinfo_mixed_block_flag;
          long_q  <= !(short_mode && !sideinfo_mixed_block_flag);
          sfb_q   <= 5'd0;
          win_q   <= 2'd0;
          state_q <= S_SEL;
        end
        S_SEL: begin
          if (sel_end) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (sel_skip) begin
            sfb_q <= sfb_q + 5'd1;
          end else begin
            width_q <= sel_width;
            req_q   <= (sel_width != 3'd0);
            cnt_q   <= sel_width;
            state_q <= (sel_width == 3'd0) ? S_ZERO : S_REQ;
          end
        end
        S_REQ, S_ZERO: if (state_q == S_ZERO || bits_valid) begin
          req_q   <= 1'b0;
          cnt_q   <= 3'd0;
          state_q <= S_WR;
          if (long_q) begin
            lwe_q   <= 1'b1;
            laddr_q <= {1'b0, sfb_q};
            ldata_q <= wr_val;
          end else begin
            swe_q   <= 1'b1;
            swin_q  <= win_q;
            sidx_q  <= sfb_q[3:0];
            sdata_q <= wr_val;
          end
        end
        S_WR: begin
          lwe_q   <= 1'b0;
          swe_q   <= 1'b0;
          state_q <= S_SEL;
          // Mixed blocks hand over from long sfb 7 to short sfb 3.
          if (long_q) begin
            if (mixed_q && sfb_q == 5'd7) begin
              long_q <= 1'b0;
              sfb_q  <= 5'd3;
              win_q  <= 2'd0;
            end else begin
              sfb_q <= sfb_q + 5'd1;
            end
          end else if (win_q == 2'd2) begin
            win_q <= 2'd0;
            sfb_q <= sfb_q + 5'd1;
          end else begin
            win_q <= win_q + 2'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stage_done                      = done_q;
  assign bits_req                        = req_q;
  assign bits_count                      = cnt_q;
  assign scalfac_long_write_enable       = lwe_q;
  assign scalfac_long_write_addr         = laddr_q;
  assign scalfac_long_write_data         = ldata_q;
  assign scalfac_short_write_enable      = swe_q;
  assign scalfac_short_write_addr_window = swin_q;
  assign scalfac_short_write_addr_index  = sidx_q;
  assign scalfac_short_write_data        = sdata_q;

endmodule
